// File: rtl/decode_exec_stage_pkg.sv
// Shared opcode/funct encodings and decoded-entry types for the decode/exec stage.
package decode_exec_stage_pkg;

   typedef logic [6:0] opcode_t;
   typedef logic [2:0] funct3_t;
   typedef logic [6:0] funct7_t;

   localparam opcode_t OPCODE_OP_IMM = 7'b0010011;
   localparam opcode_t OPCODE_AUIPC  = 7'b0010111;
   localparam opcode_t OPCODE_OP     = 7'b0110011;
   localparam opcode_t OPCODE_BRANCH = 7'b1100011;
   localparam opcode_t OPCODE_JAL    = 7'b1101111;

   localparam funct7_t FUNCT7_BASE   = 7'h00;
   localparam funct7_t FUNCT7_ALT    = 7'h20;
   localparam funct7_t FUNCT7_MULDIV = 7'h01;

   localparam int unsigned EXEC_OP_W = 4;
   typedef logic [EXEC_OP_W-1:0] exec_op_t;
   localparam exec_op_t EXEC_OP_ADD = 4'b0000;

   typedef enum logic {OP1_SEL_REG = 1'b0, OP1_SEL_PC  = 1'b1} op1_sel_t;
   typedef enum logic {OP2_SEL_REG = 1'b0, OP2_SEL_IMM = 1'b1} op2_sel_t;

   typedef struct packed {
      exec_op_t exec_op;
      op1_sel_t operand1_sel;
      op2_sel_t operand2_sel;
   } exec_unit_params;

   localparam exec_unit_params EXEC_PARAMS_RESET = '{
      exec_op:      EXEC_OP_ADD,
      operand1_sel: OP1_SEL_REG,
      operand2_sel: OP2_SEL_IMM
   };

   // Tag is kept outside this struct because its width is a stage parameter.
   typedef struct packed {
      exec_unit_params params;
      logic            muldiv;
      logic            illegal;
   } decoded_entry_t;

   localparam decoded_entry_t DECODED_RESET = '{
      params:  EXEC_PARAMS_RESET,
      muldiv:  1'b0,
      illegal: 1'b0
   };

endpackage

// File: rtl/decode_exec_stage_if.sv
// Fetch/ID-side and execute-side valid/ready bundle for decode_exec_stage.
interface decode_exec_stage_if #(
   parameter int unsigned TAG_W = 32
);
   import decode_exec_stage_pkg::*;

   logic             in_valid;
   logic             in_ready;
   opcode_t          in_opcode;
   funct3_t          in_funct3;
   funct7_t          in_funct7;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   exec_unit_params  out_params;
   logic             out_muldiv;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_opcode, in_funct3, in_funct7, in_tag, out_ready,
      input  in_ready, out_valid, out_params, out_muldiv, out_illegal, out_tag
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_funct7, in_tag, out_ready,
      output in_ready, out_valid, out_params, out_muldiv, out_illegal, out_tag
   );

endinterface

// File: rtl/exec_decode_comb.sv
// Pure combinational opcode/funct3/funct7 decode into exec params, mul/div steering and illegal flag.
module exec_decode_comb
   import decode_exec_stage_pkg::*;
#(
   parameter bit ENABLE_M      = 1'b1,
   parameter bit STRICT_FUNCT7 = 1'b1
) (
   input  opcode_t        opcode_i,
   input  funct3_t        funct3_i,
   input  funct7_t        funct7_i,
   output decoded_entry_t entry_c
);

   logic is_op;
   logic is_op_imm;
   logic f7_base;
   logic f7_alt;
   logic f7_muldiv;

   assign is_op     = (opcode_i == OPCODE_OP);
   assign is_op_imm = (opcode_i == OPCODE_OP_IMM);
   assign f7_base   = (funct7_i == FUNCT7_BASE);
   assign f7_alt    = (funct7_i == FUNCT7_ALT);
   assign f7_muldiv = (funct7_i == FUNCT7_MULDIV);

   always_comb begin
      entry_c = DECODED_RESET;

      case (opcode_i)
         OPCODE_OP: begin
            entry_c.params.exec_op      = {funct7_i[5], funct3_i};
            entry_c.params.operand2_sel = OP2_SEL_REG;
         end
         // Only the shift-right immediate uses funct7[5] (SRAI vs SRLI).
         OPCODE_OP_IMM: entry_c.params.exec_op = {(funct3_i == 3'b101) & funct7_i[5], funct3_i};
         OPCODE_BRANCH, OPCODE_JAL, OPCODE_AUIPC: entry_c.params.operand1_sel = OP1_SEL_PC;
         default: ;
      endcase

      if (ENABLE_M && is_op && f7_muldiv) begin
         entry_c.muldiv         = 1'b1;
         entry_c.params.exec_op = {1'b0, funct3_i};
      end

      if (STRICT_FUNCT7) begin
         if (is_op) begin
            entry_c.illegal = !(f7_base || f7_alt || (ENABLE_M && f7_muldiv)) ||
                              (f7_alt && (funct3_i != 3'b000) && (funct3_i != 3'b101));
         end else if (is_op_imm) begin
            entry_c.illegal = ((funct3_i == 3'b001) && !f7_base) ||
                              ((funct3_i == 3'b101) && !(f7_base || f7_alt));
         end
      end else begin
         entry_c.illegal = is_op && f7_muldiv && !ENABLE_M;
      end
   end

endmodule

// File: rtl/decode_exec_stage.sv
// Registered, flow-controlled decode stage: 1-entry pipeline register or 2-entry skid buffer
// in front of the execute stage, with synchronous flush for branch redirect.
module decode_exec_stage
   import decode_exec_stage_pkg::*;
#(
   parameter int unsigned TAG_W         = 32,
   parameter int unsigned DEPTH         = 2,
   parameter bit          ENABLE_M      = 1'b1,
   parameter bit          STRICT_FUNCT7 = 1'b1
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   decode_exec_stage_if.slave bus
);

   decoded_entry_t   dec_c;
   decoded_entry_t   main_q, main_d;
   decoded_entry_t   skid_q, skid_d;
   logic [TAG_W-1:0] main_tag_q, main_tag_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             push;
   logic             pop;

   exec_decode_comb #(
      .ENABLE_M      (ENABLE_M),
      .STRICT_FUNCT7 (STRICT_FUNCT7)
   ) u_dec (
      .opcode_i (bus.in_opcode),
      .funct3_i (bus.in_funct3),
      .funct7_i (bus.in_funct7),
      .entry_c  (dec_c)
   );

   // With a skid entry, in_ready is purely a register output; a single entry needs out_ready.
   assign bus.in_ready = (DEPTH == 1) ? (~main_valid_q | bus.out_ready) : ~skid_valid_q;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = main_valid_q & bus.out_ready;

   always_comb begin
      main_d       = main_q;
      main_tag_d   = main_tag_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_tag_d   = skid_tag_q;
      skid_valid_d = skid_valid_q;

      if (pop) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (push) begin
            main_d     = dec_c;
            main_tag_d = bus.in_tag;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (push) begin
         if (!main_valid_q) begin
            main_d       = dec_c;
            main_tag_d   = bus.in_tag;
            main_valid_d = 1'b1;
         end else if (DEPTH > 1) begin
            skid_d       = dec_c;
            skid_tag_d   = bus.in_tag;
            skid_valid_d = 1'b1;
         end
      end

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q       <= DECODED_RESET;
         main_tag_q   <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= DECODED_RESET;
         skid_tag_q   <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_tag_q   <= main_tag_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_tag_q   <= skid_tag_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.out_valid   = main_valid_q;
   assign bus.out_params  = main_q.params;
   assign bus.out_muldiv  = main_q.muldiv;
   assign bus.out_illegal = main_q.illegal;
   assign bus.out_tag     = main_tag_q;

endmodule
